// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types: jump encodings, FSM state codes, buffer entry and the NOP word.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10,
    JUMP_RSVD = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DROP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int unsigned BUF_WIDTH  = 64;
  localparam int unsigned BUF_DEPTH  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // The reserved jump code behaves exactly like "no jump".
  function automatic logic is_redirect(input logic branch, input logic [1:0] jump);
    jump_e j;
    j = jump_e'(jump);
    return branch || (j == JUMP_JAL) || (j == JUMP_JALR);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request bus plus the decoder-facing instruction stream.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// Small circular FIFO holding fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_buf #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one-outstanding-request instruction fetcher with redirect handling and a 2-entry buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [1:0]       jump,
  input  logic [31:0]      tgt_pc,
  input  logic             stall,
  inst_fetch_if.master     bus
);
  fetch_state_e state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  addr, addr_nx;
  logic [31:0]  tgt_aligned;
  logic         redirect;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  logic [1:0]   count_post;
  fetch_entry_t head;
  fetch_entry_t wdata;

  assign redirect    = is_redirect(branch_taken, jump);
  assign tgt_aligned = tgt_pc & ~32'd3;
  assign pop         = (count != 2'd0) && bus.inst_ready && !redirect;
  assign count_post  = count + 2'd1 - {1'b0, pop};
  assign wdata       = '{pc: pc, inst: bus.imem_rdata};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    addr_nx  = addr;
    push     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (redirect) begin
          pc_nx = tgt_aligned;
        end else if (!stall && count < 2'd2) begin
          state_nx = S_REQ;
          addr_nx  = pc;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_nx    = tgt_aligned;
          state_nx = bus.imem_ack ? S_IDLE : S_DROP;
        end else if (bus.imem_ack) begin
          push  = 1'b1;
          pc_nx = pc + 32'd4;
          // Back-to-back issue keeps the bus busy without an IDLE bubble.
          if (count_post < 2'd2 && !stall) addr_nx = pc + 32'd4;
          else                             state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect)     pc_nx    = tgt_aligned;
        if (bus.imem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      addr  <= addr_nx;
    end
  end

  fetch_buf #(
    .WIDTH    (BUF_WIDTH),
    .DEPTH    (BUF_DEPTH),
    .RESET_VAL({RESET_PC, NOP})
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .pop  (pop),
    .din  (wdata),
    .dout (head),
    .count(count)
  );

  // Outputs are forced to their idle values for the whole time rst is high.
  assign bus.imem_req   = !rst && (state != S_IDLE);
  assign bus.imem_addr  = rst ? RESET_PC : addr;
  assign bus.inst_valid = !rst && (count != 2'd0);
  assign bus.inst       = rst ? NOP : head.inst;
  assign bus.inst_pc    = rst ? RESET_PC : head.pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenarios plus a randomized run checked against an instruction-stream model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] tgt_pc = '0;
  logic        stall = 1'b0;

  int checks = 0;
  int errors = 0;

  inst_fetch_if bus ();
  inst_fetch_if bus2 ();

  assign bus.imem_rdata  = ~bus.imem_addr;
  assign bus2.imem_rdata = ~bus2.imem_addr;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump),
    .tgt_pc(tgt_pc), .stall(stall), .bus(bus)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump),
    .tgt_pc(tgt_pc), .stall(stall), .bus(bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic ack, input logic rdy);
    rst = 1'b1; branch_taken = 1'b0; jump = 2'b00; stall = 1'b0; tgt_pc = '0;
    bus.imem_ack = ack;  bus.inst_ready = rdy;
    bus2.imem_ack = ack; bus2.inst_ready = rdy;
    repeat (2) @(negedge clk);
    check("rst_req",    32'(bus.imem_req), 32'd0);
    check("rst_addr",   bus.imem_addr, 32'h0);
    check("rst_valid",  32'(bus.inst_valid), 32'd0);
    check("rst_inst",   bus.inst, 32'h0000_0013);
    check("rst_pc",     bus.inst_pc, 32'h0);
    check("rst2_addr",  bus2.imem_addr, 32'hFFFF_FFFC);
    check("rst2_pc",    bus2.inst_pc, 32'hFFFF_FFFC);
    rst = 1'b0;
  endtask

  task automatic wait_deliver(input logic [31:0] exp_pc, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        check({tag, "_pc"}, bus.inst_pc, exp_pc);
        check({tag, "_inst"}, bus.inst, ~exp_pc);
        return;
      end
    end
    check({tag, "_timeout"}, 32'(bus.inst_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack, prev_stall, prev_redir, redir;
    logic [31:0] prev_addr;
    int          deliveries;
    int unsigned r;

    // Ack tied high: stream 0,4,8,... with first valid two cycles after reset; wrap on dut2.
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    check("t1_n1_valid", 32'(bus.inst_valid), 32'd0);
    check("t1_n1_req2",  32'(bus2.imem_req), 32'd1);
    check("t1_n1_addr2", bus2.imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("t1_addr2_wrap", bus2.imem_addr, 32'h0);
      check("t1_valid", 32'(bus.inst_valid), 32'd1);
      check("t1_pc",    bus.inst_pc, 32'(i) * 32'd4);
      check("t1_inst",  bus.inst, ~(32'(i) * 32'd4));
      check("t1_pc2",   bus2.inst_pc, 32'hFFFF_FFFC + 32'(i) * 32'd4);
    end

    // Decoder not ready: buffer fills to two entries, then drains 0,4 back to back.
    do_reset(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("t2_req_idle", 32'(bus.imem_req), 32'd0);
    check("t2_valid",    32'(bus.inst_valid), 32'd1);
    check("t2_pc0",      bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("t2_valid1", 32'(bus.inst_valid), 32'd1);
    check("t2_pc4",    bus.inst_pc, 32'h4);
    wait_deliver(32'h8, "t2_next");

    // JALR while the request is unacknowledged: response dropped, refetch at aligned target.
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    check("t3_req", 32'(bus.imem_req), 32'd1);
    jump = 2'b10; tgt_pc = 32'h0000_0103;
    @(negedge clk);
    jump = 2'b00;
    check("t3_drop_req",  32'(bus.imem_req), 32'd1);
    check("t3_drop_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("t3_drop_hold", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("t3_drop_idle",  32'(bus.imem_req), 32'd0);
    check("t3_drop_empty", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    check("t3_new_req",  32'(bus.imem_req), 32'd1);
    check("t3_new_addr", bus.imem_addr, 32'h0000_0100);
    bus.imem_ack = 1'b1;
    wait_deliver(32'h100, "t3_deliver");

    // Branch coincident with ack and pop: buffer flushed, next delivery from target.
    do_reset(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_pre_valid", 32'(bus.inst_valid), 32'd1);
    check("t4_pre_req",   32'(bus.imem_req), 32'd1);
    branch_taken = 1'b1; tgt_pc = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    check("t4_flush", 32'(bus.inst_valid), 32'd0);
    wait_deliver(32'h40, "t4_d0");
    wait_deliver(32'h44, "t4_d1");

    // Stall: outstanding request still completes, no new issue until stall drops.
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    stall = 1'b1; bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("t5_req_blocked", 32'(bus.imem_req), 32'd0);
    check("t5_completed",   32'(bus.inst_valid), 32'd1);
    check("t5_pc0",         bus.inst_pc, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("t5_stall_hold", 32'(bus.imem_req), 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    check("t5_last_stall", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    check("t5_resume_req",  32'(bus.imem_req), 32'd1);
    check("t5_resume_addr", bus.imem_addr, 32'h4);

    // Reset pulse mid-request on the high-RESET_PC instance.
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    bus2.imem_ack = 1'b1;
    @(negedge clk);
    bus2.imem_ack = 1'b0;
    check("t6_b2b_req",  32'(bus2.imem_req), 32'd1);
    check("t6_b2b_addr", bus2.imem_addr, 32'h0);
    rst = 1'b1; bus2.imem_ack = 1'b1;
    @(negedge clk);
    check("t6_rst_req",  32'(bus2.imem_req), 32'd0);
    check("t6_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0; bus2.imem_ack = 1'b0;
    @(negedge clk);
    check("t6_after_req",   32'(bus2.imem_req), 32'd1);
    check("t6_after_addr",  bus2.imem_addr, 32'hFFFF_FFFC);
    check("t6_after_valid", 32'(bus2.inst_valid), 32'd0);

    // Randomized run against an instruction-stream model.
    do_reset(1'b0, 1'b0);
    exp_pc = 32'h0; deliveries = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_req && !prev_ack) begin
        check("rnd_req_hold",  32'(bus.imem_req), 32'd1);
        check("rnd_addr_hold", bus.imem_addr, prev_addr);
      end
      if (!prev_req && prev_stall) check("rnd_stall_block", 32'(bus.imem_req), 32'd0);
      if (prev_redir) check("rnd_flush", 32'(bus.inst_valid), 32'd0);

      bus.imem_ack   = ($urandom_range(0, 2) == 0);
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      tgt_pc         = $urandom;
      branch_taken   = 1'b0;
      jump           = 2'b00;
      r = $urandom_range(0, 39);
      case (r)
        0: branch_taken = 1'b1;
        1: jump = 2'b01;
        2: jump = 2'b10;
        3: jump = 2'b11;
        default: ;
      endcase
      redir = branch_taken || (jump == 2'b01) || (jump == 2'b10);

      if (bus.inst_valid && bus.inst_ready && !redir) begin
        check("rnd_pc",   bus.inst_pc, exp_pc);
        check("rnd_inst", bus.inst, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (redir) exp_pc = tgt_pc & ~32'd3;

      prev_req   = bus.imem_req;
      prev_ack   = bus.imem_ack;
      prev_addr  = bus.imem_addr;
      prev_stall = stall;
      prev_redir = redir;
    end
    check("rnd_progress", 32'(deliveries >= 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
